// File: rtl/param_dcache.sv
// Parameterised write-back, write-allocate data cache with LRU replacement and halt-driven flush.
// Define DCACHE_STATS_EN to keep hit/miss counters and write hit_count to 0x3100 after a flush.
module param_dcache #(
    parameter int WAYS     = 2,
    parameter int SETS     = 8,
    parameter int BLKWORDS = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        dmemREN,
    input  logic        dmemWEN,
    input  logic [31:0] dmemaddr,
    input  logic [31:0] dmemstore,
    input  logic        halt,
    output logic        dhit,
    output logic [31:0] dmemload,
    output logic        flushed,
    output logic        dREN,
    output logic        dWEN,
    output logic [31:0] daddr,
    output logic [31:0] dstore,
    input  logic        dwait,
    input  logic [31:0] dload,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
);
    localparam int IDX_W   = $clog2(SETS);
    localparam int OFF_B   = $clog2(BLKWORDS);
    localparam int WC_W    = (OFF_B > 0) ? OFF_B : 1;
    localparam int WAY_W   = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int TAG_LSB = IDX_W + OFF_B + 2;
    localparam int TAG_W   = 32 - TAG_LSB;
    localparam logic [WC_W-1:0]  WC_LAST  = WC_W'(BLKWORDS - 1);
    localparam logic [WAY_W-1:0] WAY_LAST = WAY_W'(WAYS - 1);
    localparam logic [IDX_W-1:0] SET_LAST = IDX_W'(SETS - 1);

    typedef enum logic [2:0] {
        COMPARE, WB, ALLOC, FLUSH_SCAN, FLUSH_WB, FLUSH_STATS, FLUSHED
    } state_t;

`ifdef DCACHE_STATS_EN
    localparam state_t FLUSH_END = FLUSH_STATS;
`else
    localparam state_t FLUSH_END = FLUSHED;
`endif

    state_t state, next_state;

    logic             valid    [SETS][WAYS];
    logic             dirty    [SETS][WAYS];
    logic [WAY_W-1:0] age      [SETS][WAYS];
    logic [TAG_W-1:0] tags     [SETS][WAYS];
    logic [31:0]      data_mem [SETS][WAYS][BLKWORDS];

    logic [WC_W-1:0]  wcnt;
    logic [WAY_W-1:0] victim, vict_sel, hit_way, best_age;
    logic [IDX_W-1:0] fset;
    logic [WAY_W-1:0] fway;
    logic             found_inv, hit_any, last_frame;
    logic             hit_acc, wr_hit, miss_go, fill_we, fill_done;
    logic             word_step, frame_next, flush_wb_done;

    logic             req;
    logic [TAG_W-1:0] req_tag;
    logic [IDX_W-1:0] req_idx;
    logic [WC_W-1:0]  req_off;

    function automatic logic [31:0] blk_addr(input logic [TAG_W-1:0] t,
                                             input logic [IDX_W-1:0] i,
                                             input logic [WC_W-1:0] w);
        blk_addr = (32'(t) << TAG_LSB) | (32'(i) << (OFF_B + 2)) | (32'(w) << 2);
    endfunction

    assign req     = dmemREN | dmemWEN;
    assign req_tag = TAG_W'(dmemaddr >> TAG_LSB);
    assign req_idx = IDX_W'(dmemaddr >> (OFF_B + 2));
    assign req_off = WC_W'((dmemaddr >> 2) & 32'(BLKWORDS - 1));

    // Tag match, and victim choice: first invalid way, otherwise the oldest
    always_comb begin
        hit_any   = 1'b0;
        hit_way   = '0;
        found_inv = 1'b0;
        vict_sel  = '0;
        best_age  = age[req_idx][0];
        for (int w = 0; w < WAYS; w++) begin
            if (!hit_any && valid[req_idx][w] && tags[req_idx][w] == req_tag) begin
                hit_any = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (!found_inv && !valid[req_idx][w]) begin
                found_inv = 1'b1;
                vict_sel  = WAY_W'(w);
            end
        end
        if (!found_inv) begin
            for (int w = 1; w < WAYS; w++) begin
                if (age[req_idx][w] > best_age) begin
                    best_age = age[req_idx][w];
                    vict_sel = WAY_W'(w);
                end
            end
        end
    end

    always_comb begin
        next_state    = state;
        dhit          = 1'b0;
        dmemload      = '0;
        flushed       = 1'b0;
        dREN          = 1'b0;
        dWEN          = 1'b0;
        daddr         = '0;
        dstore        = '0;
        hit_acc       = 1'b0;
        miss_go       = 1'b0;
        fill_we       = 1'b0;
        word_step     = 1'b0;
        frame_next    = 1'b0;
        flush_wb_done = 1'b0;
        last_frame    = (fset == SET_LAST) && (fway == WAY_LAST);
        if (!RST) begin
            unique case (state)
                COMPARE: begin
                    if (halt) begin
                        next_state = FLUSH_SCAN;
                    end else if (req && hit_any) begin
                        hit_acc  = 1'b1;
                        dhit     = 1'b1;
                        dmemload = dmemWEN ? dmemstore : data_mem[req_idx][hit_way][req_off];
                    end else if (req) begin
                        miss_go    = 1'b1;
                        next_state = dirty[req_idx][vict_sel] ? WB : ALLOC;
                    end
                end
                WB: begin
                    dWEN      = 1'b1;
                    daddr     = blk_addr(tags[req_idx][victim], req_idx, wcnt);
                    dstore    = data_mem[req_idx][victim][wcnt];
                    word_step = !dwait;
                    if (!dwait && wcnt == WC_LAST) next_state = ALLOC;
                end
                ALLOC: begin
                    dREN      = 1'b1;
                    daddr     = blk_addr(req_tag, req_idx, wcnt);
                    fill_we   = !dwait;
                    word_step = !dwait;
                    if (!dwait && wcnt == WC_LAST) next_state = COMPARE;
                end
                FLUSH_SCAN: begin
                    if (dirty[fset][fway]) begin
                        next_state = FLUSH_WB;
                    end else begin
                        frame_next = 1'b1;
                        if (last_frame) next_state = FLUSH_END;
                    end
                end
                FLUSH_WB: begin
                    dWEN      = 1'b1;
                    daddr     = blk_addr(tags[fset][fway], fset, wcnt);
                    dstore    = data_mem[fset][fway][wcnt];
                    word_step = !dwait;
                    if (!dwait && wcnt == WC_LAST) begin
                        flush_wb_done = 1'b1;
                        frame_next    = 1'b1;
                        next_state    = last_frame ? FLUSH_END : FLUSH_SCAN;
                    end
                end
                FLUSH_STATS: begin
                    dWEN   = 1'b1;
                    daddr  = 32'h0000_3100;
                    dstore = hit_count;
                    if (!dwait) next_state = FLUSHED;
                end
                FLUSHED: flushed = 1'b1;
                default: next_state = COMPARE;
            endcase
        end
    end

    assign wr_hit    = hit_acc & dmemWEN;
    assign fill_done = fill_we & (wcnt == WC_LAST);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state  <= COMPARE;
            wcnt   <= '0;
            victim <= '0;
            fset   <= '0;
            fway   <= '0;
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    valid[s][w] <= 1'b0;
                    dirty[s][w] <= 1'b0;
                    age[s][w]   <= '0;
                end
            end
        end else begin
            state <= next_state;
            if (miss_go) begin
                victim <= vict_sel;
                wcnt   <= '0;
            end
            if (hit_acc) begin
                if (dmemWEN) dirty[req_idx][hit_way] <= 1'b1;
                for (int w = 0; w < WAYS; w++) begin
                    if (WAY_W'(w) == hit_way)          age[req_idx][w] <= '0;
                    else if (age[req_idx][w] != WAY_LAST) age[req_idx][w] <= age[req_idx][w] + 1'b1;
                end
            end
            if (word_step) wcnt <= (wcnt == WC_LAST) ? '0 : wcnt + 1'b1;
            if (fill_done) begin
                valid[req_idx][victim] <= 1'b1;
                dirty[req_idx][victim] <= 1'b0;
            end
            if (state == COMPARE && halt) begin
                fset <= '0;
                fway <= '0;
                wcnt <= '0;
            end
            if (flush_wb_done) dirty[fset][fway] <= 1'b0;
            if (frame_next) begin
                if (fway == WAY_LAST) begin
                    fway <= '0;
                    fset <= fset + 1'b1;
                end else begin
                    fway <= fway + 1'b1;
                end
            end
        end
    end

    // Block storage carries no reset; valid bits alone qualify it
    always_ff @(posedge CLK) begin
        if (wr_hit)    data_mem[req_idx][hit_way][req_off] <= dmemstore;
        if (fill_we)   data_mem[req_idx][victim][wcnt]     <= dload;
        if (fill_done) tags[req_idx][victim]               <= req_tag;
    end

`ifdef DCACHE_STATS_EN
    logic [31:0] hit_cnt, miss_cnt;
    logic        filled;

    // The hit that completes a filled access is not counted as a hit
    always_ff @(posedge CLK) begin
        if (RST) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
            filled   <= 1'b0;
        end else begin
            if (hit_acc) begin
                filled <= 1'b0;
                if (!filled) hit_cnt <= hit_cnt + 32'd1;
            end
            if (fill_done) begin
                filled   <= 1'b1;
                miss_cnt <= miss_cnt + 32'd1;
            end
        end
    end

    assign hit_count  = RST ? 32'd0 : hit_cnt;
    assign miss_count = RST ? 32'd0 : miss_cnt;
`else
    assign hit_count  = 32'd0;
    assign miss_count = 32'd0;
`endif

endmodule

// File: doc/param_dcache.md
PARAM_DCACHE -- requirements
Module: param_dcache

Interface
REQ-001 SHALL have parameter WAYS, default 2; associativity, legal values 1, 2 or 4.
REQ-002 SHALL have parameter SETS, default 8; sets per way, power of 2, range 2..64.
REQ-003 SHALL have parameter BLKWORDS, default 2; 32-bit words per block, power of 2, range 1..8.
REQ-004 SHALL have port CLK  in  1  clock; all state updates on its rising edge.
REQ-005 SHALL have port RST  in  1  reset, synchronous and active-high.
REQ-006 SHALL have ports dmemREN, dmemWEN  in  1 each  datapath read and write request.
REQ-007 SHALL have ports dmemaddr, dmemstore  in  32 each  datapath byte address and store data.
REQ-008 SHALL have port halt  in  1  request to flush the cache.
REQ-009 SHALL have ports dhit  out  1, dmemload  out  32, flushed  out  1  datapath responses.
REQ-010 SHALL have ports dREN, dWEN  out  1 each, daddr  out  32, dstore  out  32  memory request.
REQ-011 SHALL have ports dwait  in  1, dload  in  32  memory stall and read data.
REQ-012 SHALL have ports hit_count, miss_count  out  32 each  statistics counters.

Function
REQ-013 SHALL decode the address as tag | index (log2 SETS) | block offset (log2 BLKWORDS) | byte offset (2); tag is the remaining upper bits.
REQ-014 SHALL hold per frame: valid, dirty, tag and BLKWORDS data words; SHALL hold log2(WAYS)-bit LRU age per way per set.
REQ-015 SHALL implement states COMPARE, WB, ALLOC, FLUSH_SCAN, FLUSH_WB, FLUSHED; a word counter SHALL sequence WB, ALLOC and FLUSH_WB.
REQ-016 SHALL, in COMPARE with a request on a valid tag match, assert dhit combinationally in the same cycle and drive dmemload with the addressed word.
REQ-017 SHALL, on a write hit, update the word and set dirty at the next edge, drive dmemload with dmemstore, and issue no memory traffic.
REQ-018 SHALL, on any hit, make the hit way most-recent and age the other ways in that set.
REQ-019 SHALL, on a miss, choose the victim as the lowest-index invalid way, else the least-recent way; SHALL go to WB if the victim is dirty, else to ALLOC.
REQ-020 SHALL, in WB, drive dWEN=1, daddr={victim tag, index, word counter, 00} and dstore with the victim word; SHALL advance the counter on each cycle with dwait=0 and go to ALLOC after the last word.
REQ-021 SHALL, in ALLOC, drive dREN=1 and daddr={request tag, index, word counter, 00}; SHALL capture dload on each cycle with dwait=0.
REQ-022 SHALL, after the last ALLOC word, set valid=1, dirty=0 and the new tag, increment miss_count, and return to COMPARE; the retried access then hits.
REQ-023 SHALL keep daddr and dstore stable while dwait=1.
REQ-024 SHALL drive dREN, dWEN, daddr and dstore to 0 in COMPARE and FLUSHED.
REQ-025 SHALL give halt priority over a simultaneous request in COMPARE, entering FLUSH_SCAN with the scan pointer at set 0, way 0.
REQ-026 SHALL, in FLUSH_SCAN, advance one frame per cycle, in set-major order, over all SETS*WAYS frames; dirty frames SHALL go to FLUSH_WB.
REQ-027 SHALL, in FLUSH_WB, write back all BLKWORDS words, clear dirty, and return to FLUSH_SCAN at the next frame.
REQ-028 SHALL enter FLUSHED after the last frame, hold flushed=1, accept no requests, and leave FLUSHED only by reset.
REQ-029 SHALL count one hit per access served without a fill; the dhit cycle that completes a filled access SHALL NOT increment hit_count.
REQ-030 SHALL let both 32-bit counters wrap modulo 2^32.

Reset
REQ-031 SHALL, with RST=1 at a clock edge, clear all valid, dirty and LRU state, both counters and the word counter, and enter COMPARE.
REQ-032 SHALL drive dhit=0, flushed=0, dREN=dWEN=0, daddr=dstore=0, dmemload=0 and hit_count=miss_count=0 while in reset.
REQ-033 SHALL abandon any WB, ALLOC or flush in progress on reset, with no further memory writes.

Configuration
REQ-034 SHALL, with DCACHE_STATS_EN defined, maintain both counters and, after the flush scan, write hit_count to address 0x00003100 (dWEN, honouring dwait) before entering FLUSHED.
REQ-035 SHALL, without DCACHE_STATS_EN, tie hit_count and miss_count to 0 and go directly from the last frame to FLUSHED.

Verification
REQ-036 SHALL cover a cold read of 0x100 with dload 0xA, 0xB and dwait=0: two ALLOC reads at 0x100 and 0x104, then dhit=1 with dmemload=0xA; miss_count=1.
REQ-037 SHALL cover a write hit of 0x55 to 0x104 and then a read of 0x104: dhit=1 in the same cycle for both, dmemload=0x55, no dREN or dWEN.
REQ-038 SHALL cover three tags mapping to set 0 with WAYS=2, the first one dirty: WB of the LRU frame to its old address, then ALLOC of the new tag.
REQ-039 SHALL cover dwait held high for 3 cycles during WB: daddr and dstore constant, and the counter advances only after dwait falls.
REQ-040 SHALL cover halt with 2 dirty frames and DCACHE_STATS_EN defined: 4 data writes, then a write of hit_count to 0x3100, then flushed=1.
REQ-041 SHALL cover RST pulsed mid-ALLOC: next cycle in COMPARE, all lines invalid, a read of the same address misses again.
